// File: rtl/turf_bus_arbiter.sv
// Round-robin arbiter sharing the TURF register-bus master port between the
// PLX host path (requester 0) and the housekeeping requester (requester 1).
module turf_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rq0_wr_i,
    input  logic        rq0_rd_i,
    input  logic [5:0]  rq0_addr_i,
    input  logic [1:0]  rq0_bank_i,
    input  logic [31:0] rq0_dat_i,
    output logic [31:0] rq0_dat_o,
    output logic        rq0_ack_o,
    output logic        rq0_err_o,
    input  logic        rq1_wr_i,
    input  logic        rq1_rd_i,
    input  logic [5:0]  rq1_addr_i,
    input  logic [1:0]  rq1_bank_i,
    input  logic [31:0] rq1_dat_i,
    output logic [31:0] rq1_dat_o,
    output logic        rq1_ack_o,
    output logic        rq1_err_o,
    output logic        turf_wr_o,
    output logic        turf_rd_o,
    output logic [5:0]  turf_addr_o,
    output logic [1:0]  turf_bank_o,
    output logic [31:0] turf_dat_o,
    input  logic [31:0] turf_dat_i,
    input  logic        turf_ack_i,
    output logic [1:0]  grant_o,
    output logic [7:0]  err_count_o
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        owner_r, owner_s;
    logic        last_grant_r, last_grant_s;
    logic        is_wr_r, is_wr_s;
    logic        turf_wr_r, turf_wr_s;
    logic        turf_rd_r, turf_rd_s;
    logic [5:0]  turf_addr_r, turf_addr_s;
    logic [1:0]  turf_bank_r, turf_bank_s;
    logic [31:0] turf_dat_r, turf_dat_s;
    logic [31:0] rq0_dat_r, rq0_dat_s;
    logic [31:0] rq1_dat_r, rq1_dat_s;
    logic        rq0_ack_r, rq0_ack_s;
    logic        rq1_ack_r, rq1_ack_s;
    logic        rq0_err_r, rq0_err_s;
    logic        rq1_err_r, rq1_err_s;
    logic [1:0]  grant_r, grant_s;
    logic [7:0]  err_count_r, err_count_s;

    logic        req0_s, req1_s, pick_s;
    logic        sel_wr_s;
    logic [5:0]  sel_addr_s;
    logic [1:0]  sel_bank_s;
    logic [31:0] sel_dat_s;

    // On contention the requester not granted last wins; otherwise the sole requester.
    assign req0_s     = rq0_wr_i | rq0_rd_i;
    assign req1_s     = rq1_wr_i | rq1_rd_i;
    assign pick_s     = (req0_s & req1_s) ? ~last_grant_r : req1_s;
    assign sel_wr_s   = pick_s ? rq1_wr_i   : rq0_wr_i;
    assign sel_addr_s = pick_s ? rq1_addr_i : rq0_addr_i;
    assign sel_bank_s = pick_s ? rq1_bank_i : rq0_bank_i;
    assign sel_dat_s  = pick_s ? rq1_dat_i  : rq0_dat_i;

    // Next-state and next-output logic for the grant / issue / release sequence.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        owner_s      = owner_r;
        last_grant_s = last_grant_r;
        is_wr_s      = is_wr_r;
        turf_wr_s    = turf_wr_r;
        turf_rd_s    = turf_rd_r;
        turf_addr_s  = turf_addr_r;
        turf_bank_s  = turf_bank_r;
        turf_dat_s   = turf_dat_r;
        rq0_dat_s    = rq0_dat_r;
        rq1_dat_s    = rq1_dat_r;
        rq0_ack_s    = 1'b0;
        rq1_ack_s    = 1'b0;
        rq0_err_s    = 1'b0;
        rq1_err_s    = 1'b0;
        grant_s      = grant_r;
        err_count_s  = err_count_r;

        case (state_r)
            IDLE: begin
                if (req0_s || req1_s) begin
                    owner_s      = pick_s;
                    last_grant_s = pick_s;
                    is_wr_s      = sel_wr_s;
                    turf_wr_s    = sel_wr_s;
                    turf_rd_s    = ~sel_wr_s;
                    turf_addr_s  = sel_addr_s;
                    turf_bank_s  = sel_bank_s;
                    turf_dat_s   = sel_dat_s;
                    grant_s      = pick_s ? 2'b10 : 2'b01;
                    cnt_s        = 8'd1;
                    state_s      = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (turf_ack_i) begin
                    turf_wr_s = 1'b0;
                    turf_rd_s = 1'b0;
                    grant_s   = 2'b00;
                    rq0_dat_s = (!is_wr_r && !owner_r) ? turf_dat_i : rq0_dat_r;
                    rq1_dat_s = (!is_wr_r &&  owner_r) ? turf_dat_i : rq1_dat_r;
                    rq0_ack_s = ~owner_r;
                    rq1_ack_s = owner_r;
                    state_s   = RELEASE;
                end else if (cnt_r == TIMEOUT_C) begin
                    turf_wr_s   = 1'b0;
                    turf_rd_s   = 1'b0;
                    grant_s     = 2'b00;
                    rq0_dat_s   = (!is_wr_r && !owner_r) ? ERR_DATA : rq0_dat_r;
                    rq1_dat_s   = (!is_wr_r &&  owner_r) ? ERR_DATA : rq1_dat_r;
                    rq0_err_s   = ~owner_r;
                    rq1_err_s   = owner_r;
                    err_count_s = (err_count_r == 8'hFF) ? 8'hFF : err_count_r + 8'd1;
                    state_s     = RELEASE;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            RELEASE: begin
                state_s = IDLE;
            end
            default: begin
                turf_wr_s = 1'b0;
                turf_rd_s = 1'b0;
                grant_s   = 2'b00;
                state_s   = IDLE;
            end
        endcase
    end

    // State and output registers; last_grant resets to 1 so requester 0 wins first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            cnt_r        <= 8'd0;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            is_wr_r      <= 1'b0;
            turf_wr_r    <= 1'b0;
            turf_rd_r    <= 1'b0;
            turf_addr_r  <= 6'd0;
            turf_bank_r  <= 2'd0;
            turf_dat_r   <= 32'd0;
            rq0_dat_r    <= 32'd0;
            rq1_dat_r    <= 32'd0;
            rq0_ack_r    <= 1'b0;
            rq1_ack_r    <= 1'b0;
            rq0_err_r    <= 1'b0;
            rq1_err_r    <= 1'b0;
            grant_r      <= 2'b00;
            err_count_r  <= 8'd0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            owner_r      <= owner_s;
            last_grant_r <= last_grant_s;
            is_wr_r      <= is_wr_s;
            turf_wr_r    <= turf_wr_s;
            turf_rd_r    <= turf_rd_s;
            turf_addr_r  <= turf_addr_s;
            turf_bank_r  <= turf_bank_s;
            turf_dat_r   <= turf_dat_s;
            rq0_dat_r    <= rq0_dat_s;
            rq1_dat_r    <= rq1_dat_s;
            rq0_ack_r    <= rq0_ack_s;
            rq1_ack_r    <= rq1_ack_s;
            rq0_err_r    <= rq0_err_s;
            rq1_err_r    <= rq1_err_s;
            grant_r      <= grant_s;
            err_count_r  <= err_count_s;
        end
    end

    assign rq0_dat_o   = rq0_dat_r;
    assign rq1_dat_o   = rq1_dat_r;
    assign rq0_ack_o   = rq0_ack_r;
    assign rq1_ack_o   = rq1_ack_r;
    assign rq0_err_o   = rq0_err_r;
    assign rq1_err_o   = rq1_err_r;
    assign turf_wr_o   = turf_wr_r;
    assign turf_rd_o   = turf_rd_r;
    assign turf_addr_o = turf_addr_r;
    assign turf_bank_o = turf_bank_r;
    assign turf_dat_o  = turf_dat_r;
    assign grant_o     = grant_r;
    assign err_count_o = err_count_r;

endmodule

// File: tb/tb_turf_bus_arbiter.sv
// Randomised bench for turf_bus_arbiter against a transaction-level model of
// grant order, strobe length, ack/timeout outcome, read data and error count.
module tb_turf_bus_arbiter;

    localparam int unsigned TMO     = 8;
    localparam logic [31:0] ERR_VAL = 32'hFFFF_FFFF;

    logic        clk_i;
    logic        rst_i;
    logic [1:0]  req_wr;
    logic [1:0]  req_rd;
    logic [5:0]  req_addr [2];
    logic [1:0]  req_bank [2];
    logic [31:0] req_dat  [2];
    logic [31:0] rq0_dat_o, rq1_dat_o;
    logic        rq0_ack_o, rq1_ack_o, rq0_err_o, rq1_err_o;
    logic        turf_wr_o, turf_rd_o;
    logic [5:0]  turf_addr_o;
    logic [1:0]  turf_bank_o;
    logic [31:0] turf_dat_o;
    logic [31:0] turf_dat_i;
    logic        turf_ack_i;
    logic [1:0]  grant_o;
    logic [7:0]  err_count_o;

    int          n_checks;
    int          n_fails;
    int          m_last;
    int          m_err;
    logic [31:0] m_dat [2];

    turf_bus_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERR_VAL)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rq0_wr_i    (req_wr[0]),
        .rq0_rd_i    (req_rd[0]),
        .rq0_addr_i  (req_addr[0]),
        .rq0_bank_i  (req_bank[0]),
        .rq0_dat_i   (req_dat[0]),
        .rq0_dat_o   (rq0_dat_o),
        .rq0_ack_o   (rq0_ack_o),
        .rq0_err_o   (rq0_err_o),
        .rq1_wr_i    (req_wr[1]),
        .rq1_rd_i    (req_rd[1]),
        .rq1_addr_i  (req_addr[1]),
        .rq1_bank_i  (req_bank[1]),
        .rq1_dat_i   (req_dat[1]),
        .rq1_dat_o   (rq1_dat_o),
        .rq1_ack_o   (rq1_ack_o),
        .rq1_err_o   (rq1_err_o),
        .turf_wr_o   (turf_wr_o),
        .turf_rd_o   (turf_rd_o),
        .turf_addr_o (turf_addr_o),
        .turf_bank_o (turf_bank_o),
        .turf_dat_o  (turf_dat_o),
        .turf_dat_i  (turf_dat_i),
        .turf_ack_i  (turf_ack_i),
        .grant_o     (grant_o),
        .err_count_o (err_count_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1);
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One IDLE cycle: grant must be clear and no completion pulse may linger.
    task automatic idle_cycle();
        @(negedge clk_i);
        turf_ack_i = 1'b0;
        check_value("idle_grant", grant_o, 2'b00);
        check_value("idle_pulse", {rq1_ack_o, rq0_ack_o, rq1_err_o, rq0_err_o}, 4'b0000);
    endtask

    // Called at the negedge of an IDLE cycle with requests already set.
    // d in 1..TMO: TURF acks in strobe cycle d; anything else: no ack (timeout).
    task automatic do_txn(input int d, input logic [31:0] rdata, input bit scramble, output int w);
        bit          q0, q1, acked;
        int          eff;
        logic        e_wr;
        logic [5:0]  e_addr;
        logic [1:0]  e_bank, e_grant;
        logic [31:0] e_dat;
        q0 = req_wr[0] | req_rd[0];
        q1 = req_wr[1] | req_rd[1];
        if (q0 && q1) w = (m_last == 0) ? 1 : 0;
        else          w = q0 ? 0 : 1;
        m_last  = w;
        e_wr    = req_wr[w];
        e_addr  = req_addr[w];
        e_bank  = req_bank[w];
        e_dat   = req_dat[w];
        e_grant = (w == 0) ? 2'b01 : 2'b10;
        acked   = (d >= 1) && (d <= int'(TMO));
        eff     = acked ? d : int'(TMO);
        for (int c = 1; c <= eff + 1; c++) begin
            @(negedge clk_i);
            turf_ack_i = 1'b0;
            turf_dat_i = $urandom();
            if (c <= eff) begin
                check_value("strobe_wr", turf_wr_o, e_wr);
                check_value("strobe_rd", turf_rd_o, !e_wr);
                check_value("grant", grant_o, e_grant);
                check_value("bus_addr", turf_addr_o, e_addr);
                check_value("bus_bank", turf_bank_o, e_bank);
                if (e_wr) check_value("bus_dat", turf_dat_o, e_dat);
                check_value("early_pulse", {rq1_ack_o, rq0_ack_o, rq1_err_o, rq0_err_o}, 4'b0000);
                if (acked && c == d) begin
                    turf_ack_i = 1'b1;
                    turf_dat_i = rdata;
                end
                if (scramble && c == 2) begin
                    for (int r = 0; r < 2; r++) begin
                        req_addr[r] = 6'($urandom_range(0, 63));
                        req_bank[r] = 2'($urandom_range(0, 3));
                        req_dat[r]  = $urandom();
                    end
                    if ($urandom_range(0, 3) == 0) begin
                        req_wr[w] = 1'b0;
                        req_rd[w] = 1'b0;
                    end
                end
            end else begin
                if (!e_wr) m_dat[w] = acked ? rdata : ERR_VAL;
                if (!acked && m_err < 255) m_err++;
                check_value("ack_pulse", {rq1_ack_o, rq0_ack_o}, acked ? e_grant : 2'b00);
                check_value("err_pulse", {rq1_err_o, rq0_err_o}, acked ? 2'b00 : e_grant);
                check_value("strobe_off", {turf_wr_o, turf_rd_o}, 2'b00);
                check_value("grant_off", grant_o, 2'b00);
                check_value("rq0_dat", rq0_dat_o, m_dat[0]);
                check_value("rq1_dat", rq1_dat_o, m_dat[1]);
                check_value("err_count", err_count_o, 32'(m_err));
                req_wr[w]  = 1'b0;
                req_rd[w]  = 1'b0;
                turf_ack_i = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    endtask

    initial begin
        int w;
        int pat;
        logic [1:0] k;
        n_checks   = 0;
        n_fails    = 0;
        m_last     = 1;
        m_err      = 0;
        m_dat[0]   = 32'd0;
        m_dat[1]   = 32'd0;
        rst_i      = 1'b1;
        req_wr     = 2'b00;
        req_rd     = 2'b00;
        turf_ack_i = 1'b0;
        turf_dat_i = 32'd0;
        for (int r = 0; r < 2; r++) begin
            req_addr[r] = 6'd0;
            req_bank[r] = 2'd0;
            req_dat[r]  = 32'd0;
        end

        // Reset values
        repeat (2) @(negedge clk_i);
        check_value("rst_strobe", {turf_wr_o, turf_rd_o}, 2'b00);
        check_value("rst_grant", grant_o, 2'b00);
        check_value("rst_pulse", {rq1_ack_o, rq0_ack_o, rq1_err_o, rq0_err_o}, 4'b0000);
        check_value("rst_bus", {turf_addr_o, turf_bank_o}, 8'd0);
        check_value("rst_busdat", turf_dat_o, 32'd0);
        check_value("rst_dat0", rq0_dat_o, 32'd0);
        check_value("rst_dat1", rq1_dat_o, 32'd0);
        check_value("rst_errcnt", err_count_o, 8'd0);

        // Contention from reset: both write, each re-requests right after its ack
        rst_i      = 1'b0;
        req_wr     = 2'b11;
        req_dat[0] = 32'hAAAA_0000;
        req_dat[1] = 32'hBBBB_0000;
        for (int i = 0; i < 6; i++) begin
            do_txn(int'($urandom_range(1, 3)), 32'd0, 1'b0, w);
            check_value("cont_order", 32'(w), 32'(i % 2));
            idle_cycle();
            req_wr[w]  = 1'b1;
            req_dat[w] = $urandom();
        end
        req_wr = 2'b00;

        // Single host read, TURF acks in the 4th strobe cycle
        idle_cycle();
        req_rd[0]   = 1'b1;
        req_addr[0] = 6'h05;
        req_bank[0] = 2'd2;
        do_txn(4, 32'h1234_5678, 1'b0, w);
        check_value("host_rd_dat", rq0_dat_o, 32'h1234_5678);

        // Timeout on a housekeeping read
        idle_cycle();
        req_rd[1] = 1'b1;
        do_txn(0, 32'd0, 1'b0, w);
        check_value("tmo_dat", rq1_dat_o, 32'hFFFF_FFFF);
        check_value("tmo_count", err_count_o, 8'd1);

        // Ack on the cycle the count reaches TIMEOUT: ack wins
        idle_cycle();
        req_wr[0] = 1'b1;
        do_txn(int'(TMO), 32'd0, 1'b0, w);
        check_value("edge_count", err_count_o, 8'd1);

        // Stray ack while IDLE is ignored
        idle_cycle();
        turf_ack_i = 1'b1;
        @(negedge clk_i);
        turf_ack_i = 1'b0;
        check_value("stray_pulse", {rq1_ack_o, rq0_ack_o, rq1_err_o, rq0_err_o}, 4'b0000);
        check_value("stray_state", {grant_o, turf_wr_o, turf_rd_o}, 4'b0000);

        // wr and rd together: write wins
        req_wr[0]  = 1'b1;
        req_rd[0]  = 1'b1;
        req_dat[0] = 32'hC0DE_0001;
        do_txn(2, 32'hDEAD_BEEF, 1'b0, w);

        // Randomised traffic
        for (int i = 0; i < 150; i++) begin
            idle_cycle();
            pat = int'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                k = 2'($urandom_range(1, 3));
                req_wr[r]   = pat[r] ? k[0] : 1'b0;
                req_rd[r]   = pat[r] ? k[1] : 1'b0;
                req_addr[r] = 6'($urandom_range(0, 63));
                req_bank[r] = 2'($urandom_range(0, 3));
                req_dat[r]  = $urandom();
            end
            do_txn(int'($urandom_range(1, TMO + 2)), $urandom(), 1'b1, w);
        end

        // Saturation of the timeout counter
        for (int i = 0; i < 300; i++) begin
            idle_cycle();
            req_wr    = 2'b00;
            req_rd    = 2'b10;
            do_txn(0, 32'd0, 1'b0, w);
        end
        check_value("sat_count", err_count_o, 8'd255);

        // Reset two cycles into a write
        idle_cycle();
        req_wr     = 2'b01;
        req_rd     = 2'b00;
        req_dat[0] = 32'h5A5A_0001;
        repeat (2) @(negedge clk_i);
        check_value("pre_rst_wr", turf_wr_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check_value("mid_rst_wr", turf_wr_o, 1'b0);
        check_value("mid_rst_grant", grant_o, 2'b00);
        check_value("mid_rst_pulse", {rq1_ack_o, rq0_ack_o, rq1_err_o, rq0_err_o}, 4'b0000);
        check_value("mid_rst_count", err_count_o, 8'd0);
        check_value("mid_rst_dat1", rq1_dat_o, 32'd0);
        req_wr = 2'b11;
        @(negedge clk_i);
        rst_i    = 1'b0;
        m_last   = 1;
        m_err    = 0;
        m_dat[0] = 32'd0;
        m_dat[1] = 32'd0;
        do_txn(2, 32'd0, 1'b0, w);
        check_value("post_rst_first", 32'(w), 32'd0);
        idle_cycle();
        do_txn(1, 32'd0, 1'b0, w);
        check_value("post_rst_second", 32'(w), 32'd1);
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/turf_bus_arbiter.md
# turf_bus_arbiter

Two-port arbiter that shares the single TURF register-bus master port between the PLX host path and an internal housekeeping requester. Both requesters reach the TURF FPGA over the same TURF_DIO bus.
- The block sits between the PLX local-bus decoder and TURF_interface_v2, in the pclk domain.
- It serialises transactions with round-robin fairness.
- A per-transaction ack timeout guarantees a hung TURF (e.g. during FPROG reprogramming) never deadlocks the host.

## Interface
- TIMEOUT, 255: cycles to wait for turf_ack_i before aborting; legal range 2..255.
- ERR_DATA, 32'hFFFFFFFF: read data returned on timeout.
- clk_i  in  1  pclk, the PLX local-bus clock.
- rst_i  in  1  reset; asynchronous, active-high.
- rqN_wr_i  in  1  requester N (N=0 host, N=1 housekeeping) write request; level, held until ack/err.
- rqN_rd_i  in  1  requester N read request; level.
- rqN_addr_i  in  6  requester N register address.
- rqN_bank_i  in  2  requester N TURF bank.
- rqN_dat_i  in  32  requester N write data.
- rqN_dat_o  out  32  requester N read data; valid with ack/err pulse.
- rqN_ack_o  out  1  requester N completion; one-cycle pulse.
- rqN_err_o  out  1  requester N timeout; one-cycle pulse.
- turf_wr_o  out  1  downstream write strobe; level until ack.
- turf_rd_o  out  1  downstream read strobe; level until ack.
- turf_addr_o  out  6  downstream address.
- turf_bank_o  out  2  downstream bank.
- turf_dat_o  out  32  downstream write data.
- turf_dat_i  in  32  downstream read data.
- turf_ack_i  in  1  downstream completion.
- grant_o  out  2  one-hot current owner; 00 when idle.
- err_count_o  out  8  saturating count of timeouts since reset.

## Operation
- States: IDLE, ISSUE, RELEASE.
- **IDLE**
  - A request is any of wr_i or rd_i high.
  - If only one requester is requesting, grant it.
  - If both are requesting, grant the one not granted last (last_grant register).
  - On grant, register addr, bank, dat and direction (wr wins if wr_i and rd_i are both high), set grant_o, then go to ISSUE.
- **ISSUE**
  - Hold turf_wr_o or turf_rd_o high with the registered addr/bank/dat; count cycles.
  - On turf_ack_i:
    - Drop the strobe.
    - For a read, load rqN_dat_o from turf_dat_i; for a write, leave it unchanged.
    - Pulse rqN_ack_o and go to RELEASE.
  - If the count reaches TIMEOUT with no ack:
    - Drop the strobe.
    - For a read, load rqN_dat_o with ERR_DATA.
    - Pulse rqN_err_o, increment err_count_o (saturating at 255) and go to RELEASE.
- **RELEASE**
  - One cycle; grant_o clears.
  - The requester must drop its request on the cycle it sees ack/err. RELEASE guarantees that request is not re-sampled, then the block returns to IDLE.
- last_grant updates on every grant.
- Requester inputs are sampled only at grant; changes during ISSUE are ignored.
- A request dropped mid-transaction is not aborted: the downstream transaction completes and the ack/err pulse is still issued.
- turf_ack_i in IDLE or RELEASE is ignored.
- Ack and timeout in the same cycle: ack wins; no error is counted.

## Timing
- Reset values:
  - All strobes, ack, err and grant_o are 0.
  - turf_addr/bank/dat are 0; rqN_dat_o is 0; err_count_o is 0.
  - State is IDLE; last_grant=1, so requester 0 wins the first contention.
- Reset mid-transaction: all outputs go immediately (asynchronously) to reset values; no ack/err is issued.
- Latency for a request first high at cycle n while the block is IDLE:
  - Strobe and grant_o are high from n+1.
  - turf_ack_i at cycle k≥n+1 gives ack_o and read data at k+1, strobe low at k+1, RELEASE at k+1, IDLE at k+2.
  - The next grant is sampled at k+2, so the minimum transaction is 3 cycles.
- Timeout: the strobe is high for exactly TIMEOUT cycles (n+1..n+TIMEOUT); err_o pulses at n+TIMEOUT+1.
- rqN_dat_o holds its value until the next completed read for that requester.

## Test plan
- Single host read:
  - Stimulus: rq0_rd_i, addr 6'h05, bank 2; TURF acks 4 cycles after the strobe with 32'h12345678.
  - Required: turf_rd_o high 4 cycles, addr 5/bank 2 on the bus, rq0_ack_o one-cycle pulse with rq0_dat_o=32'h12345678, grant_o=01 during the transaction.
- Contention:
  - Stimulus: rq0 and rq1 both request writes from reset, each re-requesting immediately after ack, for 6 transactions.
  - Required: grant order 0,1,0,1,0,1; turf_dat_o matches the granted requester's data; no transaction shorter than 3 cycles.
- Timeout:
  - Stimulus: TIMEOUT=8, rq1 read with no turf_ack_i.
  - Required: turf_rd_o high exactly 8 cycles, rq1_err_o pulse, rq1_dat_o=32'hFFFFFFFF, err_count_o=1, rq1_ack_o never asserted.
- Boundaries:
  - Ack on the cycle the count reaches TIMEOUT: ack_o fires, err_o stays low, err_count_o is unchanged.
  - 300 timeouts: err_count_o saturates at 255.
- Reset mid-ISSUE:
  - Stimulus: assert rst_i 2 cycles into a write.
  - Required: turf_wr_o, grant_o and ack drop in the same cycle; after release, a pending rq0 and rq1 resolve with rq0 first.
- Stray ack and wr+rd:
  - Stimulus: turf_ack_i pulsed while IDLE.
  - Required: no ack_o and no state change.
  - Stimulus: rq0_wr_i and rq0_rd_i both high.
  - Required: only turf_wr_o is asserted.
